// File: rtl/cpu_defs.sv
// Shared CPU definitions used across the EX/fetch boundary.
//   br_op_t       : control-transfer opcode classes leaving EX
//   br_resolved_t : BTB training update {valid, pc, target_pc} (layout fixed, BTB consumes it)
//   redirect_t    : fetch redirect request {valid, pc}
package cpu_defs;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_B    = 4'd7,
        BR_BL   = 4'd8,
        BR_JIRL = 4'd9
    } br_op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target_pc;
    } br_resolved_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } redirect_t;

    localparam logic [31:0] INSN_BYTES = 32'd4;

endpackage

// File: rtl/br_cond.sv
// Combinational branch condition and target evaluation.
//   op            : control-transfer class
//   pc, rj, rd    : instruction PC and source operands
//   imm           : sign-extended, pre-shifted offset
//   taken         : actual direction
//   target        : actual target (JIRL is register-relative, others PC-relative)
module br_cond
    import cpu_defs::*;
(
    input  br_op_t      op,
    input  logic [31:0] pc,
    input  logic [31:0] rj,
    input  logic [31:0] rd,
    input  logic [31:0] imm,
    output logic        taken,
    output logic [31:0] target
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rj == rd);
    assign lt_s = ($signed(rj) < $signed(rd));
    assign lt_u = (rj < rd);

    always_comb begin
        taken = 1'b0;
        unique case (op)
            BR_BEQ:                 taken = eq;
            BR_BNE:                 taken = ~eq;
            BR_BLT:                 taken = lt_s;
            BR_BGE:                 taken = ~lt_s;
            BR_BLTU:                taken = lt_u;
            BR_BGEU:                taken = ~lt_u;
            BR_B, BR_BL, BR_JIRL:   taken = 1'b1;
            default:                taken = 1'b0;
        endcase
    end

    // Targets wrap mod 2^32 and are passed unaligned-checked; fetch faults on them.
    assign target = (op == BR_JIRL) ? (rj + imm) : (pc + imm);

endmodule

// File: rtl/br_resolver.sv
// Execute-stage branch resolution unit.
// Evaluates each control transfer leaving EX, emits the registered BTB training
// update, and holds a redirect/flush request toward fetch on a misprediction.
//   clk, rst_n          : clock, synchronous active-low reset
//   ex_*                : EX-stage instruction, operands and fetch-time prediction
//   ex_resolved_out     : one-cycle BTB update pulse for taken transfers
//   redirect_valid/pc   : held redirect request, released after redirect_ready
//   redirect_ready      : fetch accepts the redirect
//   flush_younger       : squash wrong-path IF/ID/EX while redirecting
//   br_cnt, mispred_cnt : wrapping resolved-branch and misprediction counters
module br_resolver
    import cpu_defs::*;
#(
    parameter int unsigned CNT_WID = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic                ex_is_stall,
    input  logic [31:0]         ex_pc,
    input  br_op_t              ex_br_op,
    input  logic [31:0]         ex_rj,
    input  logic [31:0]         ex_rd,
    input  logic [31:0]         ex_imm,
    input  logic                ex_pred_taken,
    input  logic [31:0]         ex_pred_target,
    output br_resolved_t        ex_resolved_out,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    input  logic                redirect_ready,
    output logic                flush_younger,
    output logic [CNT_WID-1:0]  br_cnt,
    output logic [CNT_WID-1:0]  mispred_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               fire;
    logic               act_taken;
    logic [31:0]        act_target;
    logic               mispred;
    logic [31:0]        fix_pc;
    logic               load_redir;
    br_resolved_t       resolved_q;
    logic [31:0]        redirect_pc_q;
    logic [CNT_WID-1:0] br_cnt_q;
    logic [CNT_WID-1:0] mispred_cnt_q;
    redirect_t          redir;

    br_cond u_br_cond (
        .op     (ex_br_op),
        .pc     (ex_pc),
        .rj     (ex_rj),
        .rd     (ex_rd),
        .imm    (ex_imm),
        .taken  (act_taken),
        .target (act_target)
    );

    // While redirecting, EX holds wrong-path work, so nothing fires.
    assign fire    = ex_valid & ~ex_is_stall & (state_q == IDLE);
    assign mispred = (act_taken != ex_pred_taken) |
                     (act_taken & (ex_pred_target != act_target));
    // A not-taken mispredict (including a BTB false hit on NONE) resumes at pc+4.
    assign fix_pc  = act_taken ? act_target : (ex_pc + INSN_BYTES);

    always_comb begin
        state_d    = state_q;
        load_redir = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fire && mispred) begin
                    state_d    = REDIR;
                    load_redir = 1'b1;
                end
            end
            REDIR: begin
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            resolved_q    <= '0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q <= state_d;

            if (fire && act_taken) begin
                resolved_q <= '{valid: 1'b1, pc: ex_pc, target_pc: act_target};
            end else begin
                resolved_q <= '0;
            end

            if (load_redir) begin
                redirect_pc_q <= fix_pc;
            end

            if (fire && (ex_br_op != BR_NONE)) begin
                br_cnt_q <= br_cnt_q + CNT_WID'(1);
            end

            if (fire && mispred) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_WID'(1);
            end
        end
    end

    assign redir           = '{valid: (state_q == REDIR), pc: redirect_pc_q};
    assign redirect_valid  = redir.valid;
    assign redirect_pc     = redir.pc;
    assign flush_younger   = redir.valid;
    assign ex_resolved_out = resolved_q;
    assign br_cnt          = br_cnt_q;
    assign mispred_cnt     = mispred_cnt_q;

endmodule

// File: doc/br_resolver.md
# br_resolver

Execute-stage branch resolution unit: it evaluates every control-transfer instruction leaving EX and compares the real outcome with the fetch-time prediction. It produces the `br_resolved_t` update stream that trains the BTB write port. It also produces a held redirect/flush request toward fetch on a misprediction. It sits between the EX datapath and the fetch stage, and it is the write-side producer for the BTB.

## Interface
Parameters:
- `CNT_WID`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ex_valid`  in  1  EX holds a valid instruction.
- `ex_is_stall`  in  1  EX stalled; instruction does not leave EX this cycle.
- `ex_pc`  in  32  instruction PC.
- `ex_br_op`  in  `br_op_t`  NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, B, BL, JIRL.
- `ex_rj`, `ex_rd`  in  32 each  source operands.
- `ex_imm`  in  32  sign-extended, pre-shifted offset.
- `ex_pred_taken`  in  1  fetch predicted taken.
- `ex_pred_target`  in  32  fetch predicted target.
- `ex_resolved_out`  out  `br_resolved_t`  {valid, pc, target_pc}; BTB training update.
- `redirect_valid`  out  1  redirect request to fetch.
- `redirect_pc`  out  32  correct next PC.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `flush_younger`  out  1  squash the IF/ID/EX wrong-path instructions.
- `br_cnt`, `mispred_cnt`  out  `CNT_WID` each  resolved-branch and misprediction counters.

## Operation
- Fire condition: `fire = ex_valid & ~ex_is_stall & state==IDLE`.
- Taken rules:
  - BEQ/BNE: rj ==/!= rd.
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
  - B/BL/JIRL: always taken.
  - NONE: never taken.
- Target: JIRL uses `rj + ex_imm`; all others use `ex_pc + ex_imm`. Arithmetic is mod 2^32. Targets are passed unmodified; alignment faults are raised by fetch.
- Fall-through: `ex_pc + 4`.
- Misprediction: `actual_taken != ex_pred_taken`, or `actual_taken & (ex_pred_target != actual_target)`.
  - Includes a BTB false hit on NONE with `pred_taken=1`; that case redirects to pc+4.
- FSM:
  - IDLE: on `fire` with a misprediction, go to REDIR and latch `redirect_pc` (actual_target if taken, else pc+4).
  - REDIR: `redirect_valid=1` and `flush_younger=1`. All EX inputs are ignored (wrong path): no update, no counting. On `redirect_ready`, go to IDLE.
- Counters:
  - `br_cnt` increments on every `fire` with op≠NONE.
  - `mispred_cnt` increments on every `fire` with a misprediction.
  - Both wrap at 2^CNT_WID.

## Timing
- Reset (synchronous, `rst_n=0` at a clock edge):
  - state=IDLE.
  - `ex_resolved_out` all zero.
  - `redirect_valid=0`, `redirect_pc=0`, `flush_younger=0`.
  - Both counters 0.
  - Reset mid-REDIR drops the request.
- `ex_resolved_out` is registered, one cycle after `fire`:
  - valid=1 only for taken control transfers, with pc=ex_pc and target_pc=actual_target.
  - Otherwise valid=0.
  - Valid is a single-cycle pulse.
- `redirect_valid` and `flush_younger` assert the cycle after the mispredicting `fire`. They stay high, with `redirect_pc` stable, through the cycle `redirect_ready=1` is sampled, and drop the following cycle.
- `redirect_ready` sampled while `redirect_valid=0` is ignored.
- Minimum REDIR occupancy is 1 cycle; with ready held high, consecutive mispredictions can redirect every 2 cycles.
- Counters update at the edge ending the `fire` cycle.
- While `ex_is_stall=1`: no evaluation, no update, and outputs keep their pulse rules (the resolved update is not re-emitted).

## Structure
- Shared package (`cpu_defs`): `br_op_t` encoding and `br_resolved_t`.
  - `br_resolved_t` is already consumed by the BTB; its field layout is not altered.
  - Also in the package: a new `redirect_t` {valid, pc}.
- Sub-module `br_cond`: combinational taken/target evaluation from op, pc, rj, rd, imm. The top level holds the FSM, registers and counters.

## Test plan
- BEQ at pc=0x1c000100, rj=rd=5, imm=0x40, pred_taken=1, pred_target=0x1c000140 → next cycle resolved {1, 0x1c000100, 0x1c000140}; no redirect; br_cnt=1, mispred_cnt=0.
- BLT rj=0xFFFFFFFF, rd=1, pred_taken=0 → taken (signed); redirect_pc=pc+imm; the same case as BLTU is not taken, with no redirect.
- JIRL rj=0x1c002000, imm=8, pred_target=0x1c003000:
  - redirect_pc=0x1c002008.
  - `redirect_ready` held low 3 cycles: redirect_valid stays high with a stable pc, and a fired BNE in that window produces no update and no count change.
- NONE op with pred_taken=1 at pc=0x1c000200 → resolved valid=0; redirect_pc=0x1c000204; mispred_cnt increments.
- `ex_is_stall` high 2 cycles with a valid BL → nothing emitted until the cycle it drops, then exactly one resolved pulse.
- `rst_n` low during REDIR → next cycle redirect_valid=0, flush_younger=0, counters 0.
